// File: rtl/crystal_audio_pkg.sv
// -----------------------------------------------------------------------------
// crystal_audio_pkg
// Shared types and constants for the sound POKEY bus sequencer.
//   pokey_access_t : one buffered bus access {chip, ad, rw, data}
//   seq_state_t    : sequencer states (INIT burst, normal RUN)
//   SKCTL_ADDR     : POKEY SKCTL register address
//   init_entry()   : returns entry 0..3 of the fixed SKCTL init burst
// -----------------------------------------------------------------------------
package crystal_audio_pkg;

   // One access as captured from the CPU bus (rw: 1 = read, 0 = write).
   typedef struct packed {
      logic       chip;
      logic [3:0] ad;
      logic       rw;
      logic [7:0] data;
   } pokey_access_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } seq_state_t;

   localparam logic [3:0] SKCTL_ADDR       = 4'hF;
   localparam logic [7:0] INIT_CLEAR_VALUE = 8'h00;
   localparam logic [1:0] INIT_LAST_IDX    = 2'd3;

   // The burst first clears SKCTL on chip0 then chip1, and then writes the
   // final value on chip0 then chip1. Bit 0 of the index picks the chip and
   // bit 1 picks the clear or final value.
   function automatic pokey_access_t init_entry(input logic [1:0] idx,
                                                input logic [7:0] skctl);
      pokey_access_t entry;
      entry.chip = idx[0];
      entry.ad   = SKCTL_ADDR;
      entry.rw   = 1'b0;
      entry.data = idx[1] ? skctl : INIT_CLEAR_VALUE;
      return entry;
   endfunction

endpackage

// File: rtl/pokey_access_fifo.sv
// -----------------------------------------------------------------------------
// pokey_access_fifo
// Small circular buffer of captured CPU accesses.
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data (accepted when not full, or when popping)
//   push_data    : access to store
//   pop          : remove the head entry (ignored when empty)
//   head         : oldest entry
//   full, empty  : occupancy flags
//   count        : number of valid entries
//   has_read     : at least one valid entry is a read
// -----------------------------------------------------------------------------
module pokey_access_fifo
   import crystal_audio_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    push,
   input  pokey_access_t           push_data,
   input  logic                    pop,
   output pokey_access_t           head,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    has_read
);

   localparam int             PW         = $clog2(DEPTH);
   localparam logic [PW:0]    FULL_COUNT = DEPTH[PW:0];
   localparam logic [PW:0]    CNT_ONE    = 1;
   localparam logic [PW-1:0]  PTR_ONE    = 1;

   pokey_access_t  mem [DEPTH];
   logic [PW-1:0]  rd_ptr;
   logic [PW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;
   logic [PW-1:0]  slot;

   // A push into a full buffer is still accepted when the head leaves on the
   // same edge, so the occupancy simply stays at full.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
   // the count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset since validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Scan only the occupied slots, walking forward from the head, so stale
   // entries left in free slots never raise the read flag.
   always_comb begin
      has_read = 1'b0;
      slot     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr + PW'(i);
         if (((PW+1)'(i) < count) && mem[slot].rw) has_read = 1'b1;
      end
   end

endmodule

// File: rtl/pokey_bus_sequencer.sv
// -----------------------------------------------------------------------------
// pokey_bus_sequencer
// Captures CPU I/O accesses to the two sound POKEYs and replays them one at a
// time onto the POKEY port, each aligned to a single ce2Hd enable. After reset
// a fixed SKCTL init burst is written to both chips first.
//   clk, reset_n   : clock, asynchronous active-low reset
//   ce2Hd          : POKEY clock enable; a launch is consumed on a ce2Hd edge
//   CIOn           : CPU I/O select (active low), access starts on its fall
//   BA, BRWn, BD   : CPU address (BA[9] chip, BA[3:0] reg), read/write, data
//   pk_cs, pk_ad   : one-hot chip select and register address to the POKEYs
//   pk_we, pk_wdata: write enable and write data to the POKEYs
//   rdt0, rdt1     : read data from POKEY 0 and POKEY 1
//   pokey_to_cpu   : last read result, held until the next read completes
//   cpu_wait       : a CPU read is buffered or launched but not yet returned
//   busy           : init burst running or accesses still buffered
//   ovf            : sticky, an access was dropped on a full buffer
// -----------------------------------------------------------------------------
module pokey_bus_sequencer
   import crystal_audio_pkg::*;
#(
   parameter int         FIFO_DEPTH = 2,
   parameter logic [7:0] INIT_SKCTL = 8'h03
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce2Hd,
   input  logic        CIOn,
   input  logic [9:0]  BA,
   input  logic        BRWn,
   input  logic [7:0]  BD,
   output logic [1:0]  pk_cs,
   output logic [3:0]  pk_ad,
   output logic        pk_we,
   output logic [7:0]  pk_wdata,
   input  logic [7:0]  rdt0,
   input  logic [7:0]  rdt1,
   output logic [7:0]  pokey_to_cpu,
   output logic        cpu_wait,
   output logic        busy,
   output logic        ovf
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   seq_state_t     state;
   logic [1:0]     init_idx;
   logic           cion_q;
   logic           start;
   logic           launch_active;
   logic           consume;
   logic           fifo_pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic           fifo_avail;
   logic           fifo_has_read;
   logic [CW-1:0]  fifo_count;
   logic           drop;
   logic           src_valid;
   pokey_access_t  cpu_access;
   pokey_access_t  fifo_head;
   pokey_access_t  src;
   logic           unused_ba;

   // Only the chip select bit and the register nibble of the address matter.
   assign unused_ba = ^BA[8:4];

   // An access begins on the falling edge of CIOn and is captured on that
   // same clock edge.
   assign start = ~CIOn & cion_q;

   always_comb begin
      cpu_access      = '0;
      cpu_access.chip = BA[9];
      cpu_access.ad   = BA[3:0];
      cpu_access.rw   = BRWn;
      cpu_access.data = BD;
   end

   // A launch is held until a ce2Hd edge; during RUN that edge also retires
   // the head of the buffer, which stayed queued while it was on the bus.
   assign launch_active = |pk_cs;
   assign consume       = launch_active & ce2Hd;
   assign fifo_pop      = consume & (state == ST_RUN);
   assign fifo_avail    = (fifo_count != '0);
   assign drop          = start & fifo_full & ~fifo_pop;

   // The launched read is still in the buffer, so the buffer flag alone
   // covers both the queued and the in-flight reads.
   assign cpu_wait = fifo_has_read;

   // The next access to launch comes from the init table during the burst
   // and from the buffer head afterwards.
   always_comb begin
      src       = fifo_head;
      src_valid = fifo_avail;
      if (state == ST_INIT) begin
         src       = init_entry(init_idx, INIT_SKCTL);
         src_valid = 1'b1;
      end
   end

   pokey_access_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (start),
      .push_data (cpu_access),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .has_read  (fifo_has_read)
   );

   // Sequencer state, launch register and read-return register. A launch is
   // only loaded from idle, so every access is on the bus for at least one
   // full cycle and is seen by exactly one ce2Hd edge. busy is registered and
   // therefore drops one edge after the last access has been consumed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_INIT;
         init_idx     <= 2'd0;
         cion_q       <= 1'b1;
         pk_cs        <= 2'b00;
         pk_ad        <= 4'h0;
         pk_we        <= 1'b0;
         pk_wdata     <= 8'h00;
         pokey_to_cpu <= 8'h00;
         busy         <= 1'b1;
         ovf          <= 1'b0;
      end else begin
         cion_q <= CIOn;
         busy   <= (state == ST_INIT) | ~fifo_empty;
         if (drop) ovf <= 1'b1;

         if (launch_active) begin
            if (consume) begin
               pk_cs <= 2'b00;
               if (!pk_we) pokey_to_cpu <= pk_cs[1] ? rdt1 : rdt0;
               if (state == ST_INIT) begin
                  init_idx <= init_idx + 2'd1;
                  if (init_idx == INIT_LAST_IDX) state <= ST_RUN;
               end
            end
         end else if (src_valid) begin
            pk_cs    <= src.chip ? 2'b10 : 2'b01;
            pk_ad    <= src.ad;
            pk_we    <= ~src.rw;
            pk_wdata <= src.data;
         end
      end
   end

endmodule

// File: tb/tb_pokey_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pokey_bus_sequencer
// Directed bench for pokey_bus_sequencer with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pokey_bus_sequencer;

   logic        clk;
   logic        reset_n;
   logic        ce2Hd;
   logic        CIOn;
   logic [9:0]  BA;
   logic        BRWn;
   logic [7:0]  BD;
   logic [1:0]  pk_cs;
   logic [3:0]  pk_ad;
   logic        pk_we;
   logic [7:0]  pk_wdata;
   logic [7:0]  rdt0;
   logic [7:0]  rdt1;
   logic [7:0]  pokey_to_cpu;
   logic        cpu_wait;
   logic        busy;
   logic        ovf;

   int num_checks = 0;
   int num_fail   = 0;

   pokey_bus_sequencer #(
      .FIFO_DEPTH (2),
      .INIT_SKCTL (8'h03)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ce2Hd        (ce2Hd),
      .CIOn         (CIOn),
      .BA           (BA),
      .BRWn         (BRWn),
      .BD           (BD),
      .pk_cs        (pk_cs),
      .pk_ad        (pk_ad),
      .pk_we        (pk_we),
      .pk_wdata     (pk_wdata),
      .rdt0         (rdt0),
      .rdt1         (rdt1),
      .pokey_to_cpu (pokey_to_cpu),
      .cpu_wait     (cpu_wait),
      .busy         (busy),
      .ovf          (ovf)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Advance one clock with the given enable level, settle just after the edge.
   task automatic step(input logic ce);
      ce2Hd = ce;
      @(posedge clk);
      #1;
   endtask

   // One CPU access: CIOn low for one edge (ce2Hd level given for that edge),
   // then high again for one edge with ce2Hd low.
   task automatic applyStimulus(input logic [9:0] ba, input logic rw,
                                input logic [7:0] bd, input logic ce);
      BA   = ba;
      BRWn = rw;
      BD   = bd;
      CIOn = 1'b0;
      step(ce);
      CIOn = 1'b1;
      step(1'b0);
   endtask

   task automatic checkLaunch(input string tag, input logic [1:0] cs,
                              input logic [3:0] ad, input logic we,
                              input logic [7:0] wdata);
      checkOutput({tag, "_cs"},    16'(pk_cs),    16'(cs));
      checkOutput({tag, "_ad"},    16'(pk_ad),    16'(ad));
      checkOutput({tag, "_we"},    16'(pk_we),    16'(we));
      checkOutput({tag, "_wdata"}, 16'(pk_wdata), 16'(wdata));
   endtask

   // Init burst entry k: chip0, chip1, chip0, chip1 at register F with data
   // 00, 00, 03, 03.
   function automatic logic [1:0] initCs(input int k);
      return (k % 2 == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [7:0] initData(input int k);
      return (k >= 2) ? 8'h03 : 8'h00;
   endfunction

   initial begin
      reset_n = 1'b0;
      ce2Hd   = 1'b0;
      CIOn    = 1'b1;
      BA      = 10'h000;
      BRWn    = 1'b0;
      BD      = 8'h00;
      rdt0    = 8'h00;
      rdt1    = 8'hC3;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_pk_cs",    16'(pk_cs),        16'h0);
      checkOutput("rst_pk_ad",    16'(pk_ad),        16'h0);
      checkOutput("rst_pk_we",    16'(pk_we),        16'h0);
      checkOutput("rst_pk_wdata", 16'(pk_wdata),     16'h0);
      checkOutput("rst_p2c",      16'(pokey_to_cpu), 16'h0);
      checkOutput("rst_cpu_wait", 16'(cpu_wait),     16'h0);
      checkOutput("rst_busy",     16'(busy),         16'h1);
      checkOutput("rst_ovf",      16'(ovf),          16'h0);
      reset_n = 1'b1;

      // Init burst with ce2Hd every 4th clock.
      for (int k = 0; k < 4; k++) begin
         step(1'b0);
         checkLaunch($sformatf("init%0d", k), initCs(k), 4'hF, 1'b1, initData(k));
         step(1'b0);
         step(1'b0);
         checkOutput($sformatf("init%0d_hold", k), 16'(pk_cs), 16'(initCs(k)));
         step(1'b1);
         checkOutput($sformatf("init%0d_done", k), 16'(pk_cs), 16'h0);
      end
      checkOutput("init_busy_last", 16'(busy), 16'h1);
      step(1'b0);
      checkOutput("init_busy_drop", 16'(busy), 16'h0);
      checkOutput("init_idle_cs",   16'(pk_cs), 16'h0);

      // CPU write to chip1 reg 5.
      applyStimulus(10'h205, 1'b0, 8'hA5, 1'b0);
      checkLaunch("wr205", 2'b10, 4'h5, 1'b1, 8'hA5);
      step(1'b1);
      checkOutput("wr205_done", 16'(pk_cs), 16'h0);

      // CPU read of chip0 reg A.
      applyStimulus(10'h00A, 1'b1, 8'h00, 1'b0);
      checkOutput("rd_wait", 16'(cpu_wait), 16'h1);
      checkLaunch("rd00A", 2'b01, 4'hA, 1'b0, 8'h00);
      rdt0 = 8'h3C;
      step(1'b1);
      checkOutput("rd_data",     16'(pokey_to_cpu), 16'h3C);
      checkOutput("rd_wait_clr", 16'(cpu_wait),     16'h0);
      rdt0 = 8'h55;
      step(1'b0);
      step(1'b1);
      checkOutput("rd_hold", 16'(pokey_to_cpu), 16'h3C);

      // Three starts with ce2Hd low: third is dropped.
      applyStimulus(10'h001, 1'b0, 8'h11, 1'b0);
      applyStimulus(10'h202, 1'b0, 8'h22, 1'b0);
      applyStimulus(10'h003, 1'b0, 8'h33, 1'b0);
      checkOutput("ovf_set", 16'(ovf), 16'h1);
      checkLaunch("ovf_first", 2'b01, 4'h1, 1'b1, 8'h11);
      step(1'b1);
      step(1'b0);
      checkLaunch("ovf_second", 2'b10, 4'h2, 1'b1, 8'h22);
      step(1'b1);
      step(1'b0);
      checkOutput("ovf_third_gone", 16'(pk_cs), 16'h0);
      checkOutput("ovf_sticky",     16'(ovf),   16'h1);

      // Reset in the middle of a launch.
      applyStimulus(10'h20F, 1'b0, 8'h77, 1'b0);
      checkOutput("pre_rst_cs", 16'(pk_cs), 16'h2);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_cs",   16'(pk_cs), 16'h0);
      checkOutput("mid_rst_ovf",  16'(ovf),   16'h0);
      checkOutput("mid_rst_busy", 16'(busy),  16'h1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Restarted init burst with a CPU write captured during it.
      step(1'b0);
      applyStimulus(10'h206, 1'b0, 8'h5A, 1'b0);
      for (int k = 0; k < 4; k++) begin
         if (k != 0) step(1'b0);
         checkLaunch($sformatf("reinit%0d", k), initCs(k), 4'hF, 1'b1, initData(k));
         step(1'b1);
         checkOutput($sformatf("reinit%0d_done", k), 16'(pk_cs), 16'h0);
      end
      step(1'b0);
      checkLaunch("init_wr206", 2'b10, 4'h6, 1'b1, 8'h5A);
      checkOutput("init_wr_busy", 16'(busy), 16'h1);
      step(1'b1);
      step(1'b0);
      checkOutput("init_wr_busy_drop", 16'(busy), 16'h0);

      // Full buffer with a start landing on the consuming edge.
      applyStimulus(10'h001, 1'b0, 8'hD1, 1'b0);
      applyStimulus(10'h202, 1'b0, 8'hE2, 1'b0);
      checkLaunch("full_head", 2'b01, 4'h1, 1'b1, 8'hD1);
      applyStimulus(10'h003, 1'b0, 8'hF3, 1'b1);
      checkOutput("full_no_ovf", 16'(ovf), 16'h0);
      checkLaunch("full_second", 2'b10, 4'h2, 1'b1, 8'hE2);
      step(1'b1);
      step(1'b0);
      checkLaunch("full_third", 2'b01, 4'h3, 1'b1, 8'hF3);
      step(1'b1);
      checkOutput("full_done_cs",  16'(pk_cs), 16'h0);
      checkOutput("full_ovf_zero", 16'(ovf),   16'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               num_checks, num_fail);
      $finish;
   end

endmodule
